quarter_mac_ctrl: RTL
=====================

# quarter_mac_ctrl

Sequencing controller for one `quarter_unit` (four-bitbrick fused multiplier).
- Accepts a job descriptor: precision mode, signedness and vector length.
- Streams operand words from an upstream requester into the unit and drives its shift-control and sign inputs.
- Reduces the unit's lane products and accumulates them into one dot-product result.
- Returns the result on a valid/ready port. Sits between the operand buffers and the PE accumulator network.

## Interface
- `LEN_W`, default 10: width of job length (max 2^LEN_W−1 operand words).
- `ACC_W`, default 32: accumulator/result width.
- `QU_LAT`, default 1: cycles from registered `qu_a`/`qu_b` to valid `qu_out`.
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_valid`/`cfg_ready`  in/out  1  job descriptor handshake.
- `cfg_mode`  in  2  0 = 2x2 (sft 0000), 1 = 4a×2b (0101), 2 = 2a×4b (0110), 3 = 4×4 (1011).
- `cfg_sa`, `cfg_sb`  in  1  operand A / B signed.
- `cfg_len`  in  LEN_W  operand words in the job.
- `op_valid`/`op_ready`  in/out  1  operand handshake.
- `op_a`, `op_b`  in  4  operand word.
- `qu_a`, `qu_b`  out  4  registered operands to the unit.
- `qu_sa`, `qu_sb`  out  2  per-slice sign flags.
- `qu_sft_ctrl_1`, `qu_sft_ctrl_2`  out  1; `qu_sft_ctrl_3`  out  2  mode select.
- `qu_out`  in  16  unit result.
- `res_valid`/`res_ready`  out/in  1  result handshake.
- `res_data`  out  ACC_W  accumulated dot product.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `cfg_ready`=1.
  - On `cfg_valid`: latch mode, signs and len, and clear the accumulator and counters.
  - If len=0, go to DONE with result 0. Otherwise go to RUN.
- **RUN**
  - `op_ready`=1.
  - Each op handshake loads `qu_a`/`qu_b`, pushes a 1 into a QU_LAT-deep valid shift register and increments the issued count.
  - With no handshake, `qu_a`/`qu_b` load 0 and a 0 is pushed.
  - When the issued count reaches len, go to DRAIN; `op_ready` drops on the same edge as the last accept.
- **DRAIN**: `op_ready`=0. When the shift register is empty and the last accumulate has landed, go to DONE.
- **DONE**
  - `res_valid`=1, with `res_data` held stable.
  - `res_valid` and `res_data` stay held until `res_ready`, then return to IDLE.
  - `cfg_ready`=0 in DONE.
- **Shift-control outputs**: set from the latched mode at the cfg accept; held between jobs.
- **Slice signs**
  - 4-bit-wide operand: sign flag on the top slice only, e.g. `qu_sa`={cfg_sa,0}.
  - 2-bit-sliced operand: `qu_sa`={cfg_sa,cfg_sa}. Same rule for B.
- **Lane reduction** (sign-extend lane fields if cfg_sa|cfg_sb, else zero-extend, all to ACC_W):
  - mode 0: sum of the four 4-bit fields `qu_out`[3:0], [7:4], [11:8], [15:12].
  - modes 1/2: `qu_out`[7:0] + `qu_out`[15:8].
  - mode 3: `qu_out`[15:0].
- **Accumulator**: adds the lane sum when the shift-register tail is 1. Wraps modulo 2^ACC_W with no saturation.
- **Reset** (also mid-job): state IDLE, all outputs 0, accumulator/counters 0, shift register cleared. In-flight products are discarded.
- **Simultaneous events**
  - A `cfg_valid` in any state other than IDLE is not accepted.
  - An `op_valid` outside RUN is not accepted.

## Timing
- `cfg_ready` is 1 after reset; all other outputs reset to 0.
- An operand accepted at edge k appears on `qu_a`/`qu_b` after k. Its product is accumulated at edge k+QU_LAT.
- `res_valid` rises after edge k_last+QU_LAT, one cycle after the final accumulate.
- Full-rate throughput is one operand word per cycle. `op_valid` gaps insert bubbles only.
- Minimum job-to-job gap is one IDLE cycle after the result handshake.

## Structure
- `quarter_ctrl_pkg` holds:
  - `mode_e` and `state_e` enums;
  - `sft_ctrl` encoding function (mode → {sft_ctrl_3, sft_ctrl_2, sft_ctrl_1});
  - slice-sign function.
- Sub-module `qu_lane_reduce`: combinational lane extraction, extension and sum; inputs `qu_out`, mode and signed flag.

## Test plan
- Mode 3, unsigned, len=2, (15,15), (3,2) -> `res_data`=231; `res_valid` one cycle after the last accumulate.
- Mode 3, signed A/B, len=1, a=4'h8, b=4'h7 -> `res_data`=32'hFFFFFFC8; `qu_sa`=2'b10, `qu_sft_ctrl_3`=2'b10, `qu_sft_ctrl_2`=1, `qu_sft_ctrl_1`=1.
- Mode 0, unsigned, len=3, a=b=4'hF each word, with `op_valid` deasserted 2 cycles mid-stream -> `res_data`=108 (4 lanes × 9 × 3); no extra accumulates.
- len=0 job -> DONE on the next cycle, `res_data`=0; `op_ready` never asserted.
- Hold `res_ready`=0 for 5 cycles -> `res_valid` and `res_data` stable, `cfg_valid` not accepted; accepted after the handshake.
- Assert `rst` mid-RUN with 2 products in flight -> all outputs 0 and `cfg_ready`=1 next cycle; a following job result has no contamination.

Source files
------------

// File: rtl/quarter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quarter_ctrl_pkg
// Description : Shared types and encoding helpers for the quarter_unit
//               sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package quarter_ctrl_pkg;

    // Bit 0 set: A is a full 4-bit operand; bit 1 set: B is a full 4-bit operand.
    typedef enum logic [1:0] {
        MODE_2X2   = 2'd0,
        MODE_4AX2B = 2'd1,
        MODE_2AX4B = 2'd2,
        MODE_4X4   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Returns {sft_ctrl_3[1:0], sft_ctrl_2, sft_ctrl_1}.
    function automatic logic [3:0] sft_ctrl_enc(input mode_e mode);
        logic [3:0] enc;
        case (mode)
            MODE_2X2:   enc = 4'b0000;
            MODE_4AX2B: enc = 4'b0101;
            MODE_2AX4B: enc = 4'b0110;
            default:    enc = 4'b1011;
        endcase
        return enc;
    endfunction

    // Returns {qu_sa[1:0], qu_sb[1:0]}; a wide operand only flags its top slice.
    function automatic logic [3:0] slice_sign(input mode_e mode, input logic sa, input logic sb);
        logic [1:0] sa_vec;
        logic [1:0] sb_vec;
        sa_vec = mode[0] ? {sa, 1'b0} : {sa, sa};
        sb_vec = mode[1] ? {sb, 1'b0} : {sb, sb};
        return {sa_vec, sb_vec};
    endfunction

endpackage
`default_nettype wire

// File: rtl/qu_lane_reduce.sv
`default_nettype none
// ============================================================================
// Module      : qu_lane_reduce
// Description : Extracts, extends and sums the quarter_unit lane products.
// Revision    : 1.0 - initial release
// ============================================================================
module qu_lane_reduce
    import quarter_ctrl_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic [15:0]      qu_out,
    input  mode_e            mode,
    input  logic             sgn,
    output logic [ACC_W-1:0] lane_sum
);

    function automatic logic [ACC_W-1:0] ext4(input logic [3:0] f, input logic s);
        return {{(ACC_W-4){s & f[3]}}, f};
    endfunction

    function automatic logic [ACC_W-1:0] ext8(input logic [7:0] f, input logic s);
        return {{(ACC_W-8){s & f[7]}}, f};
    endfunction

    function automatic logic [ACC_W-1:0] ext16(input logic [15:0] f, input logic s);
        return {{(ACC_W-16){s & f[15]}}, f};
    endfunction

    always_comb begin
        lane_sum = '0;
        case (mode)
            MODE_2X2:   lane_sum = ext4(qu_out[3:0], sgn)  + ext4(qu_out[7:4], sgn)
                                 + ext4(qu_out[11:8], sgn) + ext4(qu_out[15:12], sgn);
            MODE_4AX2B,
            MODE_2AX4B: lane_sum = ext8(qu_out[7:0], sgn) + ext8(qu_out[15:8], sgn);
            default:    lane_sum = ext16(qu_out, sgn);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/quarter_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : quarter_mac_ctrl
// Description : Streams operand words through one quarter_unit and accumulates
//               the reduced lane products into a dot-product result.
// Revision    : 1.0 - initial release
// ============================================================================
module quarter_mac_ctrl
    import quarter_ctrl_pkg::*;
#(
    parameter int LEN_W  = 10,
    parameter int ACC_W  = 32,
    parameter int QU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_sa,
    input  logic             cfg_sb,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_a,
    input  logic [3:0]       op_b,
    output logic [3:0]       qu_a,
    output logic [3:0]       qu_b,
    output logic [1:0]       qu_sa,
    output logic [1:0]       qu_sb,
    output logic             qu_sft_ctrl_1,
    output logic             qu_sft_ctrl_2,
    output logic [1:0]       qu_sft_ctrl_3,
    input  logic [15:0]      qu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             busy
);

    state_e            r_state;
    state_e            w_state_next;
    mode_e             r_mode;
    logic              r_sgn;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issued;
    logic [QU_LAT-1:0] r_vsr;
    logic [QU_LAT-1:0] w_vsr_next;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_lane_sum;
    logic              w_cfg_fire;
    logic              w_op_fire;
    logic              w_last_issue;

    assign w_cfg_fire   = cfg_valid && cfg_ready;
    assign w_op_fire    = op_valid && op_ready;
    assign w_last_issue = w_op_fire && (r_issued == r_len - LEN_W'(1));
    assign res_data     = r_acc;

    // Valid tracker: index 0 is the issue end, QU_LAT-1 lines up with qu_out.
    generate
        if (QU_LAT == 1) begin : g_vsr_single
            assign w_vsr_next = w_op_fire;
        end else begin : g_vsr_multi
            assign w_vsr_next = {r_vsr[QU_LAT-2:0], w_op_fire};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // DRAIN exits on the edge that retires the last product, so res_valid
    // follows the final accumulate with no dead cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (cfg_valid) w_state_next = (cfg_len == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (w_last_issue) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_vsr_next == '0) w_state_next = ST_DONE;
            ST_DONE:  if (res_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_RUN:  op_ready  = 1'b1;
            ST_DONE: res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode        <= MODE_2X2;
            r_sgn         <= 1'b0;
            r_len         <= '0;
            r_issued      <= '0;
            r_vsr         <= '0;
            r_acc         <= '0;
            qu_a          <= '0;
            qu_b          <= '0;
            qu_sa         <= '0;
            qu_sb         <= '0;
            qu_sft_ctrl_3 <= '0;
            qu_sft_ctrl_2 <= 1'b0;
            qu_sft_ctrl_1 <= 1'b0;
        end else begin
            qu_a  <= w_op_fire ? op_a : 4'd0;
            qu_b  <= w_op_fire ? op_b : 4'd0;
            r_vsr <= w_vsr_next;
            if (w_cfg_fire) begin
                r_mode   <= mode_e'(cfg_mode);
                r_sgn    <= cfg_sa | cfg_sb;
                r_len    <= cfg_len;
                r_issued <= '0;
                r_acc    <= '0;
                {qu_sft_ctrl_3, qu_sft_ctrl_2, qu_sft_ctrl_1} <= sft_ctrl_enc(mode_e'(cfg_mode));
                {qu_sa, qu_sb} <= slice_sign(mode_e'(cfg_mode), cfg_sa, cfg_sb);
            end else begin
                if (w_op_fire) begin
                    r_issued <= r_issued + LEN_W'(1);
                end
                if (r_vsr[QU_LAT-1]) begin
                    r_acc <= r_acc + w_lane_sum;
                end
            end
        end
    end

    qu_lane_reduce #(
        .ACC_W (ACC_W)
    ) u_lane_reduce (
        .qu_out   (qu_out),
        .mode     (r_mode),
        .sgn      (r_sgn),
        .lane_sum (w_lane_sum)
    );

endmodule
`default_nettype wire
